// File: rtl/shadow_stack_chk.sv
// Return-address shadow stack on the commit ports: pushes call links, pops on returns, compares with the next committed PC.
// Latency: alarms and depth are registered, visible the cycle after the commit; never stalls commit (observe-only).

package riscv;
   localparam int unsigned VLEN = 39;
endpackage

package ariane_pkg;
   localparam int NR_COMMIT_PORTS = 2;

   typedef enum logic [3:0] {
      ADD, LOAD, STORE, BRANCH, JAL, JALR
   } fu_op;

   // Only the scoreboard fields this checker looks at.
   typedef struct packed {
      logic [riscv::VLEN-1:0] pc;
      fu_op                   op;
      logic [4:0]             rs1;
      logic [4:0]             rd;
      logic                   is_compressed;
   } scoreboard_entry_t;
endpackage

module shadow_stack_chk
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned VLEN  = riscv::VLEN
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
   input  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i,
   input  logic                                   flush_i,
   output logic                                   mismatch_o,
   output logic [VLEN-1:0]                        mismatch_addr_o,
   output logic                                   underflow_o,
   output logic                                   overflow_o,
   output logic [$clog2(DEPTH):0]                 depth_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [VLEN-1:0] stack_q [DEPTH];
   logic [PW-1:0]   top_q, top_d;
   logic [CW-1:0]   cnt_d;
   logic            pend_q, pend_d;
   logic [VLEN-1:0] pend_val_q, pend_val_d;
   logic            mis_d, unf_d, ovf_d;
   logic [VLEN-1:0] mis_addr_d;

   logic [NR_COMMIT_PORTS-1:0] wr_en;
   logic [PW-1:0]              wr_idx [NR_COMMIT_PORTS];
   logic [VLEN-1:0]            wr_dat [NR_COMMIT_PORTS];

   logic [VLEN-1:0] pc, link, pop_val;
   logic            is_call, is_ret;

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   // Ports are walked in commit order so each sees the stack state left by the previous one.
   always_comb begin
      top_d      = top_q;
      cnt_d      = depth_o;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      mis_d      = 1'b0;
      unf_d      = 1'b0;
      ovf_d      = 1'b0;
      mis_addr_d = mismatch_addr_o;
      wr_en      = '0;
      pc         = '0;
      link       = '0;
      pop_val    = '0;
      is_call    = 1'b0;
      is_ret     = 1'b0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         wr_idx[i] = '0;
         wr_dat[i] = '0;
      end
      if (!flush_i) begin
         for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (commit_ack_i[i]) begin
               pc      = commit_instr_i[i].pc[VLEN-1:0];
               link    = pc + (commit_instr_i[i].is_compressed ? VLEN'(2) : VLEN'(4));
               is_call = (commit_instr_i[i].op == JALR) && is_link(commit_instr_i[i].rd);
               is_ret  = (commit_instr_i[i].op == JALR) && is_link(commit_instr_i[i].rs1)
                         && (commit_instr_i[i].rd == 5'd0) && !is_call;
               if (pend_d) begin
                  pend_d = 1'b0;
                  if (pc != pend_val_d) begin
                     mis_d      = 1'b1;
                     mis_addr_d = pend_val_d;
                  end
               end
               if (is_call) begin
                  top_d     = top_d + 1'b1;
                  wr_en[i]  = 1'b1;
                  wr_idx[i] = top_d;
                  wr_dat[i] = link;
                  if (cnt_d == CW'(DEPTH)) ovf_d = 1'b1;
                  else                     cnt_d = cnt_d + 1'b1;
               end else if (is_ret) begin
                  if (cnt_d == '0) begin
                     unf_d = 1'b1;
                  end else begin
                     // A push earlier in this cycle is not in the array yet.
                     pop_val = stack_q[top_d];
                     for (int j = 0; j < i; j++)
                        if (wr_en[j] && (wr_idx[j] == top_d)) pop_val = wr_dat[j];
                     pend_d     = 1'b1;
                     pend_val_d = pop_val;
                     top_d      = top_d - 1'b1;
                     cnt_d      = cnt_d - 1'b1;
                  end
               end
            end
         end
      end else begin
         cnt_d  = '0;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         top_q           <= '0;
         depth_o         <= '0;
         pend_q          <= 1'b0;
         pend_val_q      <= '0;
         mismatch_o      <= 1'b0;
         mismatch_addr_o <= '0;
         underflow_o     <= 1'b0;
         overflow_o      <= 1'b0;
      end else begin
         top_q           <= top_d;
         depth_o         <= cnt_d;
         pend_q          <= pend_d;
         pend_val_q      <= pend_val_d;
         mismatch_o      <= mis_d;
         mismatch_addr_o <= mis_addr_d;
         underflow_o     <= unf_d;
         overflow_o      <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_COMMIT_PORTS; i++)
         if (wr_en[i]) stack_q[wr_idx[i]] <= wr_dat[i];
   end

endmodule

// File: tb/tb_shadow_stack_chk.sv
// Testbench for shadow_stack_chk: directed scenarios plus random commits against a queue-based return-stack model.
module tb_shadow_stack_chk;
   import ariane_pkg::*;

   localparam int DEPTH = 16;
   localparam int VLEN  = riscv::VLEN;
   typedef logic [VLEN-1:0] addr_t;

   logic                      clk = 1'b0;
   logic                      rst_n;
   scoreboard_entry_t [1:0]   instr;
   logic [1:0]                ack;
   logic                      flush;
   logic                      mismatch_o, underflow_o, overflow_o;
   logic [VLEN-1:0]           mismatch_addr_o;
   logic [$clog2(DEPTH):0]    depth_o;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: a bounded return-address stack as a queue (back = top).
   addr_t m_stack[$];
   bit    m_pend;
   addr_t m_pval;
   bit    e_mis, e_unf, e_ovf;
   addr_t e_addr;

   always #5 clk = ~clk;

   shadow_stack_chk #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .commit_instr_i  (instr),
      .commit_ack_i    (ack),
      .flush_i         (flush),
      .mismatch_o      (mismatch_o),
      .mismatch_addr_o (mismatch_addr_o),
      .underflow_o     (underflow_o),
      .overflow_o      (overflow_o),
      .depth_o         (depth_o)
   );

   function automatic scoreboard_entry_t mk(addr_t pc, fu_op op, logic [4:0] rd, logic [4:0] rs1, logic c);
      scoreboard_entry_t e;
      e.pc = pc; e.op = op; e.rd = rd; e.rs1 = rs1; e.is_compressed = c;
      return e;
   endfunction
   function automatic scoreboard_entry_t call_i(addr_t pc, logic c);
      return mk(pc, JALR, 5'd1, 5'd10, c);
   endfunction
   function automatic scoreboard_entry_t ret_i(addr_t pc);
      return mk(pc, JALR, 5'd0, 5'd1, 1'b0);
   endfunction
   function automatic scoreboard_entry_t plain(addr_t pc);
      return mk(pc, ADD, 5'd3, 5'd4, 1'b0);
   endfunction

   function automatic bit lr(logic [4:0] r);
      return r == 5'd1 || r == 5'd5;
   endfunction

   task automatic model_port(input scoreboard_entry_t e);
      addr_t tgt;
      if (m_pend) begin
         m_pend = 0;
         if (e.pc != m_pval) begin e_mis = 1; e_addr = m_pval; end
      end
      if (e.op == JALR && lr(e.rd)) begin
         tgt = e.pc + (e.is_compressed ? 2 : 4);
         if (m_stack.size() == DEPTH) begin void'(m_stack.pop_front()); e_ovf = 1; end
         m_stack.push_back(tgt);
      end else if (e.op == JALR && lr(e.rs1) && e.rd == 5'd0) begin
         if (m_stack.size() == 0) e_unf = 1;
         else begin m_pval = m_stack.pop_back(); m_pend = 1; end
      end
   endtask

   task automatic model_reset();
      m_stack.delete(); m_pend = 0; m_pval = '0;
      e_mis = 0; e_unf = 0; e_ovf = 0; e_addr = '0;
   endtask

   // Apply one commit cycle, advance the model, return #1 after the sampling edge.
   task automatic step(input logic [1:0] a, input scoreboard_entry_t i0, input scoreboard_entry_t i1, input logic fl);
      @(negedge clk);
      ack = a; instr[0] = i0; instr[1] = i1; flush = fl;
      e_mis = 0; e_unf = 0; e_ovf = 0;
      if (fl) begin m_stack.delete(); m_pend = 0; end
      else begin
         if (a[0]) model_port(i0);
         if (a[1]) model_port(i1);
      end
      @(posedge clk); #1;
      ack = '0; flush = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b exp 0", mismatch_o); end
      n_checks++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL reset_unf: got %b exp 0", underflow_o); end
      n_checks++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b exp 0", overflow_o); end
      n_checks++; if (mismatch_addr_o !== '0) begin n_err++; $display("FAIL reset_addr: got %0h exp 0", mismatch_addr_o); end
      n_checks++; if (depth_o !== '0) begin n_err++; $display("FAIL reset_depth: got %0d exp 0", depth_o); end
   endtask

   task automatic test_call_ret_match();
      step(2'b00, plain('0), plain('0), 1'b1);
      step(2'b01, call_i(39'h8000_0000, 1'b0), plain('0), 1'b0);
      n_checks++; if (depth_o !== 5'd1) begin n_err++; $display("FAIL match_depth1: got %0d exp 1", depth_o); end
      step(2'b01, ret_i(39'h9000_0000), plain('0), 1'b0);
      n_checks++; if (depth_o !== 5'd0) begin n_err++; $display("FAIL match_depth0: got %0d exp 0", depth_o); end
      step(2'b00, plain('0), plain('0), 1'b0);
      step(2'b01, plain(39'h8000_0004), plain('0), 1'b0);
      n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL match_mis: got %b exp 0", mismatch_o); end
      n_checks++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL match_unf: got %b exp 0", underflow_o); end
   endtask

   task automatic test_ret_mismatch();
      step(2'b00, plain('0), plain('0), 1'b1);
      step(2'b01, call_i(39'h8000_0000, 1'b0), plain('0), 1'b0);
      step(2'b01, ret_i(39'h9000_0000), plain('0), 1'b0);
      step(2'b01, plain(39'h8000_0100), plain('0), 1'b0);
      n_checks++; if (mismatch_o !== 1'b1) begin n_err++; $display("FAIL mism_pulse: got %b exp 1", mismatch_o); end
      n_checks++; if (mismatch_addr_o !== 39'h8000_0004) begin n_err++; $display("FAIL mism_addr: got %0h exp 80000004", mismatch_addr_o); end
      step(2'b00, plain('0), plain('0), 1'b0);
      n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL mism_one_cycle: got %b exp 0", mismatch_o); end
      n_checks++; if (mismatch_addr_o !== 39'h8000_0004) begin n_err++; $display("FAIL mism_addr_hold: got %0h exp 80000004", mismatch_addr_o); end
   endtask

   task automatic test_compressed_dual();
      step(2'b00, plain('0), plain('0), 1'b1);
      step(2'b11, call_i(39'h100, 1'b1), ret_i(39'h300), 1'b0);
      n_checks++; if (depth_o !== 5'd0) begin n_err++; $display("FAIL cdual_depth: got %0d exp 0", depth_o); end
      n_checks++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL cdual_unf: got %b exp 0", underflow_o); end
      step(2'b01, plain(39'h102), plain('0), 1'b0);
      n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL cdual_mis: got %b exp 0", mismatch_o); end
      step(2'b11, call_i(39'h100, 1'b1), ret_i(39'h300), 1'b0);
      step(2'b01, plain(39'h104), plain('0), 1'b0);
      n_checks++; if (mismatch_o !== 1'b1) begin n_err++; $display("FAIL cdual_bad_mis: got %b exp 1", mismatch_o); end
      n_checks++; if (mismatch_addr_o !== 39'h102) begin n_err++; $display("FAIL cdual_bad_addr: got %0h exp 102", mismatch_addr_o); end
   endtask

   task automatic test_back_to_back();
      step(2'b00, plain('0), plain('0), 1'b1);
      step(2'b11, call_i(39'h400, 1'b0), call_i(39'h500, 1'b0), 1'b0);
      n_checks++; if (depth_o !== 5'd2) begin n_err++; $display("FAIL b2b_push2: got %0d exp 2", depth_o); end
      step(2'b11, ret_i(39'h600), ret_i(39'h504), 1'b0);
      n_checks++; if (depth_o !== 5'd0) begin n_err++; $display("FAIL b2b_pop2: got %0d exp 0", depth_o); end
      n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL b2b_mis_p1: got %b exp 0", mismatch_o); end
      step(2'b01, plain(39'h408), plain('0), 1'b0);
      n_checks++; if (mismatch_o !== 1'b1) begin n_err++; $display("FAIL b2b_mis_pend: got %b exp 1", mismatch_o); end
      n_checks++; if (mismatch_addr_o !== 39'h404) begin n_err++; $display("FAIL b2b_addr: got %0h exp 404", mismatch_addr_o); end
   endtask

   task automatic test_overflow_underflow();
      addr_t pc;
      step(2'b00, plain('0), plain('0), 1'b1);
      for (int k = 0; k <= 16; k++) begin
         step(2'b01, call_i(39'h2000 + 39'(8 * k), 1'b0), plain('0), 1'b0);
         n_checks++; if (overflow_o !== (k == 16)) begin n_err++; $display("FAIL ovf_pulse[%0d]: got %b exp %b", k, overflow_o, k == 16); end
         n_checks++; if (depth_o !== 5'((k < 16) ? k + 1 : 16)) begin n_err++; $display("FAIL ovf_depth[%0d]: got %0d", k, depth_o); end
      end
      for (int k = 1; k <= 17; k++) begin
         pc = (k == 1) ? 39'h9000 : 39'h2000 + 39'(8 * (18 - k) + 4);
         step(2'b01, ret_i(pc), plain('0), 1'b0);
         n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL unf_mis[%0d]: got %b exp 0", k, mismatch_o); end
         n_checks++; if (underflow_o !== (k == 17)) begin n_err++; $display("FAIL unf_pulse[%0d]: got %b exp %b", k, underflow_o, k == 17); end
         n_checks++; if (depth_o !== 5'((k <= 16) ? 16 - k : 0)) begin n_err++; $display("FAIL unf_depth[%0d]: got %0d", k, depth_o); end
      end
   endtask

   task automatic test_flush();
      step(2'b00, plain('0), plain('0), 1'b1);
      for (int k = 0; k < 3; k++) step(2'b01, call_i(39'h700 + 39'(16 * k), 1'b0), plain('0), 1'b0);
      n_checks++; if (depth_o !== 5'd3) begin n_err++; $display("FAIL flush_pre: got %0d exp 3", depth_o); end
      step(2'b01, call_i(39'h800, 1'b0), plain('0), 1'b1);
      n_checks++; if (depth_o !== 5'd0) begin n_err++; $display("FAIL flush_depth: got %0d exp 0", depth_o); end
      n_checks++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL flush_ovf: got %b exp 0", overflow_o); end
      step(2'b01, ret_i(39'h900), plain('0), 1'b0);
      n_checks++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL flush_unf: got %b exp 1", underflow_o); end
      step(2'b01, plain(39'h1234), plain('0), 1'b0);
      n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL flush_mis: got %b exp 0", mismatch_o); end
   endtask

   task automatic test_random();
      logic [1:0]        a;
      scoreboard_entry_t ins [2];
      int                kind;
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            kind = $urandom_range(0, 9);
            ins[p] = plain((VLEN'($urandom_range(0, 8)) == 8) ? {VLEN{1'b1}} - 1 : 39'h1000 + 39'(2 * $urandom_range(0, 7)));
            if (kind <= 3)      begin ins[p].op = JALR; ins[p].rd = ($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5; ins[p].is_compressed = 1'($urandom_range(0, 1)); end
            else if (kind <= 6) begin ins[p].op = JALR; ins[p].rd = 5'd0; ins[p].rs1 = ($urandom_range(0, 1) != 0) ? 5'd1 : 5'd5; end
            else if (kind == 7) begin ins[p].op = JALR; ins[p].rd = 5'd5; ins[p].rs1 = 5'd1; end
         end
         if (m_pend && $urandom_range(0, 1) != 0) ins[0].pc = m_pval;
         kind = $urandom_range(0, 9);
         a = (kind == 0) ? 2'b00 : (kind <= 5) ? 2'b01 : 2'b11;
         step(a, ins[0], ins[1], $urandom_range(0, 29) == 0);
         n_checks++; if (mismatch_o !== e_mis) begin n_err++; $display("FAIL rnd_mis[%0d]: got %b exp %b", n, mismatch_o, e_mis); end
         n_checks++; if (mismatch_addr_o !== e_addr) begin n_err++; $display("FAIL rnd_addr[%0d]: got %0h exp %0h", n, mismatch_addr_o, e_addr); end
         n_checks++; if (underflow_o !== e_unf) begin n_err++; $display("FAIL rnd_unf[%0d]: got %b exp %b", n, underflow_o, e_unf); end
         n_checks++; if (overflow_o !== e_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d]: got %b exp %b", n, overflow_o, e_ovf); end
         n_checks++; if (depth_o !== 5'(m_stack.size())) begin n_err++; $display("FAIL rnd_depth[%0d]: got %0d exp %0d", n, depth_o, m_stack.size()); end
      end
   endtask

   task automatic test_async_reset();
      step(2'b00, plain('0), plain('0), 1'b1);
      step(2'b01, call_i(39'hA00, 1'b0), plain('0), 1'b0);
      step(2'b01, ret_i(39'hB00), plain('0), 1'b0);
      step(2'b01, plain(39'hC00), plain('0), 1'b0);
      step(2'b11, call_i(39'hD00, 1'b0), call_i(39'hE00, 1'b0), 1'b0);
      step(2'b01, ret_i(39'hF00), plain('0), 1'b0);
      n_checks++; if (mismatch_addr_o !== 39'hA04) begin n_err++; $display("FAIL arst_pre_addr: got %0h exp a04", mismatch_addr_o); end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++; if (depth_o !== 5'd0) begin n_err++; $display("FAIL arst_depth: got %0d exp 0", depth_o); end
      n_checks++; if (mismatch_addr_o !== '0) begin n_err++; $display("FAIL arst_addr: got %0h exp 0", mismatch_addr_o); end
      n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL arst_mis: got %b exp 0", mismatch_o); end
      @(negedge clk) rst_n = 1'b1;
      step(2'b01, plain(39'h5550), plain('0), 1'b0);
      n_checks++; if (mismatch_o !== 1'b0) begin n_err++; $display("FAIL arst_post_mis: got %b exp 0", mismatch_o); end
      n_checks++; if (depth_o !== 5'd0) begin n_err++; $display("FAIL arst_post_depth: got %0d exp 0", depth_o); end
   endtask

   initial begin
      rst_n = 1'b0;
      ack   = '0;
      flush = 1'b0;
      instr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk) rst_n = 1'b1;
      test_call_ret_match();
      test_ret_mismatch();
      test_compressed_dual();
      test_back_to_back();
      test_overflow_underflow();
      test_flush();
      step(2'b00, plain('0), plain('0), 1'b1);
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/shadow_stack_chk.md
# shadow_stack_chk

Return-address checker on the scoreboard commit interface, complementing the commit-side JALR/NOP detector. Pushes the link address of every committed call, pops it on every committed return, and compares it against the PC of the next committed instruction, i.e. the actual return target. Sits beside the commit stage: it only reads the commit ports and raises registered alarm pulses for the CFI response logic.

## Interface
- `DEPTH`, 16: shadow stack entries. Power of two, ≥ 2.
- `VLEN`, `riscv::VLEN`: address width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Asynchronous, active-low; one clock.
- `commit_instr_i`  in  `scoreboard_entry_t [NR_COMMIT_PORTS-1:0]`  committing instructions (`ariane_pkg`).
- `commit_ack_i`  in  `NR_COMMIT_PORTS`  port i commits this cycle.
- `flush_i`  in  1  empty the stack. Asserted on context switch or `fence`.
- `mismatch_o`  out  1  one-cycle pulse: return target ≠ popped address.
- `mismatch_addr_o`  out  VLEN  expected address of the last mismatch. Held until the next mismatch.
- `underflow_o`  out  1  one-cycle pulse: return committed with the stack empty.
- `overflow_o`  out  1  one-cycle pulse: push onto a full stack, oldest entry lost.
- `depth_o`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
- Port i is valid when `commit_ack_i[i]`. Ports are processed in order: port 0 first, then port 1. Port 1 is never acked without port 0.
- Link register: x1 or x5.
- Call: `op==JALR` and `rd` is a link register. Push `pc + (is_compressed ? 2 : 4)`, truncated to VLEN.
- Return: `op==JALR`, `rs1` is a link register, `rd==x0`. Pop the top entry into the pending-compare register and set the `pend` flag.
- A JALR that is both call and return is treated as a call only.
- Compare: the first valid port after a return, in the same cycle or a later one, supplies the target PC.
  - Compare that PC with the pending value and clear `pend`.
  - If they differ, pulse `mismatch_o` and latch the expected value into `mismatch_addr_o`.
  - The comparing instruction is then processed normally: it may itself be a call or a return.
- Stack: circular buffer with top pointer and saturating count `depth_o`.
  - Push when full: overwrite the oldest entry, count stays `DEPTH`, pulse `overflow_o`.
  - Pop when empty: no pend, pulse `underflow_o`, no compare.
- Per cycle: up to 2 operations, applied sequentially.
  - A push on port 0 followed by a pop on port 1 forwards the just-pushed value. Net depth is unchanged.
  - Two pushes in one cycle give +2, with overflow checked per push.
  - Return on port 0 plus any valid port 1: the compare uses port 1's PC in that cycle. If port 1 is a return, its pop occurs after that compare, leaving `pend` set.
- `flush_i`: depth ← 0, `pend` ← 0, no alarms. Same-cycle commits are ignored.
- No valid ports: state is held, `pend` persists.

## Timing
- All outputs are registered. Pulses assert the cycle after the commit cycle that produced the event and last exactly 1 cycle.
- `depth_o` reflects all of cycle N's commits in cycle N+1.
- Same cycle N may pulse several alarms, e.g. underflow on port 1 and mismatch from port 0's compare. Each is a separate output.
- Reset values: `mismatch_o`, `underflow_o`, `overflow_o` = 0; `mismatch_addr_o` = 0; `depth_o` = 0; `pend` = 0.
- Stack contents are not reset; reads are gated by count.
- Reset asserted mid-operation: all state clears immediately and asynchronously. An in-flight pending compare is discarded, with no pulse.

## Test plan
- Call/return, matched.
  - Stimulus: port 0 call at pc `0x8000_0000`, 4-byte, `rd=x1`. Later, return `jalr x0,0(x1)`. Next commit pc `0x8000_0004`.
  - Response: depth 1 then 0. No pulses.
- Return, mismatched.
  - Stimulus: same call, but the next commit pc is `0x8000_0100`.
  - Response: `mismatch_o`=1 for one cycle. `mismatch_addr_o=0x8000_0004`.
- Compressed call plus dual commit.
  - Stimulus: port 0 `c.jalr` at `0x100`; port 1 return in the same cycle.
  - Response: forwarded pop of `0x102`. Depth stays 0. Next cycle port 0 pc `0x102` gives no mismatch.
- Overflow and underflow.
  - Stimulus: 17 calls with `DEPTH`=16, then 17 returns with correct targets.
  - Response: `overflow_o` pulses once and depth saturates at 16. The first 16 returns give no mismatch; the 17th gives an `underflow_o` pulse.
- Flush.
  - Stimulus: 3 calls, then `flush_i`.
  - Response: depth 0. A subsequent return gives `underflow_o` and no mismatch.
- Async reset with `pend` set.
  - Stimulus: return committed, then `rst_ni` low before the next commit.
  - Response: all outputs 0. The following commit gives no mismatch.
